// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_pkg
//  Description : Shared encodings for the vector completion path: major
//                opcodes, funct3/funct6 values used to classify issued
//                instructions, the memory FSM state type and a decode helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vector_pkg;

  // Major opcodes
  localparam logic [6:0] OP_V     = 7'b1010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100111;

  // funct3 categories of OP_V
  localparam logic [2:0] FUNCT3_OPFVV = 3'b001;
  localparam logic [2:0] FUNCT3_OPMVV = 3'b010;
  localparam logic [2:0] FUNCT3_OPFVF = 3'b101;
  localparam logic [2:0] FUNCT3_OPMVX = 3'b110;
  localparam logic [2:0] FUNCT3_VSET  = 3'b111;

  // Integer multiply / multiply-accumulate funct6 encodings (OPMVV/OPMVX)
  localparam logic [5:0] FUNCT6_VMUL    = 6'b100101;
  localparam logic [5:0] FUNCT6_VMULH   = 6'b100111;
  localparam logic [5:0] FUNCT6_VMULHU  = 6'b100100;
  localparam logic [5:0] FUNCT6_VMULHSU = 6'b100110;
  localparam logic [5:0] FUNCT6_VMACC   = 6'b101101;
  localparam logic [5:0] FUNCT6_VMADD   = 6'b101001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_fsm_t;

  typedef struct packed {
    logic alu;    // completes through the ALU completion FIFO
    logic mul;    // ALU op with multi-cycle latency
    logic load;
    logic store;
  } vec_decode_t;

  function automatic logic is_mul_funct6(input logic [5:0] funct6);
    return (funct6 == FUNCT6_VMUL)    || (funct6 == FUNCT6_VMULH)  ||
           (funct6 == FUNCT6_VMULHU)  || (funct6 == FUNCT6_VMULHSU) ||
           (funct6 == FUNCT6_VMACC)   || (funct6 == FUNCT6_VMADD);
  endfunction

  function automatic vec_decode_t decode_instr(input logic [6:0] opcode,
                                               input logic [2:0] funct3,
                                               input logic [5:0] funct6);
    vec_decode_t d;
    logic        mul_cat;
    d       = '0;
    mul_cat = (funct3 == FUNCT3_OPMVV) || (funct3 == FUNCT3_OPMVX);
    d.alu   = (opcode == OP_V) && (funct3 != FUNCT3_VSET);
    d.mul   = d.alu && ((funct3 == FUNCT3_OPFVV) || (funct3 == FUNCT3_OPFVF) ||
                        (mul_cat && is_mul_funct6(funct6)));
    d.load  = (opcode == OP_LOAD);
    d.store = (opcode == OP_STORE);
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_completion_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_completion_fifo
//  Description : Synchronous FIFO of completed ALU destination registers.
//                Two write ports per cycle (port 0 is the older entry and is
//                stored first), one read per cycle.
//  Ports       : clk, rst (async, active-low)
//                wr0_en_i/wr0_data_i  older write
//                wr1_en_i/wr1_data_i  younger write
//                rd_en_i              pop head (ignored when empty)
//                head_o, empty_o, count_o
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_completion_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [DATA_W-1:0]        wr1_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic [1:0]        n_wr;
  logic              do_rd;
  logic [DATA_W-1:0] first_data;

  assign do_rd      = rd_en_i && (count_q != '0);
  assign n_wr       = {1'b0, wr0_en_i} + {1'b0, wr1_en_i};
  // With a single write the entry lands at the write pointer regardless of port.
  assign first_data = wr0_en_i ? wr0_data_i : wr1_data_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    count_d  = count_q + (PTR_W+1)'(n_wr) - (PTR_W+1)'(do_rd);
  end

  // Storage carries no reset; entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (wr0_en_i || wr1_en_i) begin
      mem_q[wr_ptr_q] <= first_data;
    end
    if (wr0_en_i && wr1_en_i) begin
      mem_q[wr_ptr_q + PTR_W'(1)] <= wr1_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, count_q} + (PTR_W+2)'(n_wr) - (PTR_W+2)'(do_rd)) <= (PTR_W+2)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/vector_completion_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vector_completion_unit
//  Description : Receives issued vector instructions, models ALU and memory
//                execution timing and returns completion events to the
//                dispatch scoreboard. Drives a single-outstanding request /
//                response interface toward the vector memory unit.
//  Ports       : clk, rst (async, active-low)
//                valid_vector/instruction/ready_vector   issue handshake
//                mem_req_valid/store/dest, mem_req_ready  memory request
//                mem_resp_valid                           memory response
//                operation_done/alu_dest                  ALU completion
//                read_done/store_done/mem_dest            memory completion
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_completion_unit
  import vector_pkg::*;
#(
  parameter int INSTRUCTION_BITS            = 32,
  parameter int REGISTER_NUMBERS            = 32,
  parameter int MULTICYCLE_OPERATION_CYCLES = 2,
  parameter int ALU_QUEUE_DEPTH             = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_vector,
  input  logic [INSTRUCTION_BITS-1:0]         instruction,
  output logic                                ready_vector,
  output logic                                mem_req_valid,
  output logic                                mem_req_store,
  output logic [$clog2(REGISTER_NUMBERS)-1:0] mem_req_dest,
  input  logic                                mem_req_ready,
  input  logic                                mem_resp_valid,
  output logic                                operation_done,
  output logic [$clog2(REGISTER_NUMBERS)-1:0] alu_dest,
  output logic                                read_done,
  output logic                                store_done,
  output logic [$clog2(REGISTER_NUMBERS)-1:0] mem_dest
);

  localparam int DEST_W = $clog2(REGISTER_NUMBERS);
  localparam int CNT_W  = $clog2(ALU_QUEUE_DEPTH) + 1;
  localparam int MC_W   = $clog2(MULTICYCLE_OPERATION_CYCLES) + 1;
  localparam logic [MC_W-1:0] MC_LAST   = MC_W'(MULTICYCLE_OPERATION_CYCLES - 1);
  localparam logic [CNT_W:0]  ALU_LIMIT = (CNT_W+1)'(ALU_QUEUE_DEPTH);

  // ---------------------------------------------------------------- decode
  vec_decode_t       dec;
  logic [DEST_W-1:0] dest;
  logic              unused_instr_bits;

  assign dec  = decode_instr(instruction[6:0], instruction[14:12], instruction[31:26]);
  assign dest = instruction[7 +: DEST_W];
  assign unused_instr_bits = ^instruction[25:15];

  // ------------------------------------------------------------ handshake
  logic             accept;
  logic             simple_push;
  logic             mul_accept;
  logic             mem_accept;
  logic             alu_room;
  logic             mem_room;
  logic [CNT_W-1:0] fifo_count;

  mem_fsm_t          mem_state_q, mem_state_d;
  logic [DEST_W-1:0] mem_dest_q,  mem_dest_d;
  logic              mem_store_q, mem_store_d;

  logic              slot_busy_q, slot_busy_d;
  logic [DEST_W-1:0] slot_dest_q, slot_dest_d;
  logic [MC_W-1:0]   mc_cnt_q,    mc_cnt_d;
  logic              slot_push;

  // The pending multicycle op already owns a FIFO entry, so count it here to
  // guarantee the slot and a simple op can both be pushed in the same cycle.
  assign alu_room = (({1'b0, fifo_count} + {{CNT_W{1'b0}}, slot_busy_q}) < ALU_LIMIT);
  // A new memory op may be taken in the DONE cycle: the port frees up next cycle.
  assign mem_room = (mem_state_q == IDLE) || (mem_state_q == DONE);

  always_comb begin
    ready_vector = 1'b1;
    if (dec.alu) begin
      ready_vector = alu_room;
    end else if (dec.load || dec.store) begin
      ready_vector = mem_room;
    end
    // Held low throughout reset so no output is driven while in reset.
    ready_vector = ready_vector && rst;
  end

  assign accept      = valid_vector && ready_vector;
  assign simple_push = accept && dec.alu && !dec.mul;
  assign mul_accept  = accept && dec.mul;
  assign mem_accept  = accept && (dec.load || dec.store);

  // ----------------------------------------------------- multicycle slot
  // The counter holds the number of cycles elapsed since accept (accept
  // cycle = 0); the entry is pushed at the end of cycle MC-1.
  assign slot_push = slot_busy_q && (mc_cnt_q == MC_LAST);

  always_comb begin
    slot_busy_d = slot_busy_q;
    slot_dest_d = slot_dest_q;
    mc_cnt_d    = mc_cnt_q;
    if (slot_push) begin
      slot_busy_d = 1'b0;
      mc_cnt_d    = '0;
    end else if (slot_busy_q) begin
      mc_cnt_d = mc_cnt_q + MC_W'(1);
    end
    if (mul_accept) begin
      slot_busy_d = 1'b1;
      slot_dest_d = dest;
      mc_cnt_d    = MC_W'(1);
    end
  end

  // ------------------------------------------------- ALU completion FIFO
  logic fifo_empty;

  alu_completion_fifo #(
    .DEPTH  (ALU_QUEUE_DEPTH),
    .DATA_W (DEST_W)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr0_en_i   (slot_push),
    .wr0_data_i (slot_dest_q),
    .wr1_en_i   (simple_push),
    .wr1_data_i (dest),
    .rd_en_i    (1'b1),
    .head_o     (alu_dest),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // The head is popped every cycle it is valid, so one completion per cycle.
  assign operation_done = !fifo_empty;

  // ----------------------------------------------------------- memory FSM
  always_comb begin
    mem_state_d   = mem_state_q;
    mem_dest_d    = mem_dest_q;
    mem_store_d   = mem_store_q;
    mem_req_valid = 1'b0;
    mem_req_store = 1'b0;
    mem_req_dest  = '0;
    read_done     = 1'b0;
    store_done    = 1'b0;
    mem_dest      = '0;

    case (mem_state_q)
      IDLE: begin
        if (mem_accept) begin
          mem_state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_store = mem_store_q;
        mem_req_dest  = mem_dest_q;
        if (mem_req_ready) begin
          mem_state_d = mem_resp_valid ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          mem_state_d = DONE;
        end
      end
      DONE: begin
        read_done   = !mem_store_q;
        store_done  = mem_store_q;
        mem_dest    = mem_dest_q;
        mem_state_d = mem_accept ? REQ : IDLE;
      end
      default: begin
        mem_state_d = IDLE;
      end
    endcase

    if (mem_accept) begin
      mem_dest_d  = dest;
      mem_store_d = dec.store;
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_state_q <= IDLE;
      mem_dest_q  <= '0;
      mem_store_q <= 1'b0;
      slot_busy_q <= 1'b0;
      slot_dest_q <= '0;
      mc_cnt_q    <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      mem_dest_q  <= mem_dest_d;
      mem_store_q <= mem_store_d;
      slot_busy_q <= slot_busy_d;
      slot_dest_q <= slot_dest_d;
      mc_cnt_q    <= mc_cnt_d;
    end
  end

  // The issuing scoreboard never sends a second multicycle op while one is pending.
  a_single_slot : assert property (@(posedge clk) disable iff (!rst)
    !(mul_accept && slot_busy_q));

endmodule
`default_nettype wire

// File: tb/tb_vector_completion_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_completion_unit
//  Description : Self-checking bench for vector_completion_unit. A cycle table
//                gives per-cycle expected outputs; a scoreboard queue checks
//                completion order against accepted instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_completion_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_vector = 1'b0;
  logic [31:0] instruction = '0;
  logic        ready_vector;
  logic        mem_req_valid, mem_req_store;
  logic [4:0]  mem_req_dest;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic        operation_done;
  logic [4:0]  alu_dest;
  logic        read_done, store_done;
  logic [4:0]  mem_dest;

  always #5 clk = ~clk;

  // A two-entry FIFO lets a multicycle/simple collision fill the queue.
  vector_completion_unit #(
    .INSTRUCTION_BITS            (32),
    .REGISTER_NUMBERS            (32),
    .MULTICYCLE_OPERATION_CYCLES (2),
    .ALU_QUEUE_DEPTH             (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_vector   (valid_vector),
    .instruction    (instruction),
    .ready_vector   (ready_vector),
    .mem_req_valid  (mem_req_valid),
    .mem_req_store  (mem_req_store),
    .mem_req_dest   (mem_req_dest),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .operation_done (operation_done),
    .alu_dest       (alu_dest),
    .read_done      (read_done),
    .store_done     (store_done),
    .mem_dest       (mem_dest)
  );

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        rq;
    logic        rs;
    logic [20:0] exp;
  } row_t;

  int         checks = 0;
  int         failures = 0;
  logic [4:0] alu_q[$];
  logic [5:0] mem_q[$];
  row_t       rows[32];

  // Expected output vector: rdy, op_done, alu_dest, req_valid, req_store,
  // req_dest, read_done, store_done, mem_dest
  function automatic logic [20:0] E(int rdy, int op, int ad, int rv, int rst_,
                                    int rd, int ld, int sd, int md);
    return {1'(rdy), 1'(op), 5'(ad), 1'(rv), 1'(rst_), 5'(rd), 1'(ld), 1'(sd), 5'(md)};
  endfunction

  function automatic row_t R(int v, logic [31:0] ins, int rq, int rs, logic [20:0] e);
    row_t r;
    r.v = 1'(v); r.ins = ins; r.rq = 1'(rq); r.rs = 1'(rs); r.exp = e;
    return r;
  endfunction

  function automatic logic [31:0] VOP(logic [5:0] f6, logic [2:0] f3, int d);
    return {f6, 1'b1, 5'd0, 5'd0, f3, 5'(d), 7'b1010111};
  endfunction
  function automatic logic [31:0] ADD(int d);  return VOP(6'b000000, 3'b000, d); endfunction
  function automatic logic [31:0] MUL(int d);  return VOP(6'b100101, 3'b010, d); endfunction
  function automatic logic [31:0] FADD(int d); return VOP(6'b000000, 3'b001, d); endfunction
  function automatic logic [31:0] RED(int d);  return VOP(6'b000000, 3'b010, d); endfunction
  function automatic logic [31:0] VSET(int d); return VOP(6'b000000, 3'b111, d); endfunction
  function automatic logic [31:0] LD(int d);   return {17'd0, 3'b000, 5'(d), 7'b0000111}; endfunction
  function automatic logic [31:0] ST(int d);   return {17'd0, 3'b000, 5'(d), 7'b0100111}; endfunction

  function automatic logic [20:0] actual();
    return {ready_vector, operation_done, alu_dest, mem_req_valid, mem_req_store,
            mem_req_dest, read_done, store_done, mem_dest};
  endfunction

  task automatic cmp(input string nm, input logic [20:0] exp);
    logic [20:0] a;
    a = actual();
    checks++;
    if (a !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, exp);
    end
  endtask

  // Completion monitor plus push of newly accepted instructions.
  task automatic sb_step();
    logic [4:0] ea;
    logic [5:0] em;
    if (operation_done) begin
      checks++;
      if (alu_q.size() == 0) begin
        failures++;
        $display("FAIL sb_alu: got dest %0d expected no completion", alu_dest);
      end else begin
        ea = alu_q.pop_front();
        if (alu_dest !== ea) begin
          failures++;
          $display("FAIL sb_alu: got dest %0d expected %0d", alu_dest, ea);
        end
      end
    end
    if (read_done || store_done) begin
      checks++;
      if (mem_q.size() == 0 || (read_done && store_done)) begin
        failures++;
        $display("FAIL sb_mem: got rd=%b st=%b dest %0d expected no completion",
                 read_done, store_done, mem_dest);
      end else begin
        em = mem_q.pop_front();
        if ({store_done, mem_dest} !== em) begin
          failures++;
          $display("FAIL sb_mem: got st=%b dest %0d expected st=%b dest %0d",
                   store_done, mem_dest, em[5], em[4:0]);
        end
      end
    end
    if (valid_vector && ready_vector) begin
      if (instruction[6:0] == 7'b1010111 && instruction[14:12] != 3'b111)
        alu_q.push_back(instruction[11:7]);
      else if (instruction[6:0] == 7'b0000111 || instruction[6:0] == 7'b0100111)
        mem_q.push_back({instruction[6:0] == 7'b0100111, instruction[11:7]});
    end
  endtask

  task automatic run_row(input string nm, input row_t r);
    @(posedge clk);
    #1;
    valid_vector   = r.v;
    instruction    = r.ins;
    mem_req_ready  = r.rq;
    mem_resp_valid = r.rs;
    @(negedge clk);
    cmp(nm, r.exp);
    sb_step();
  endtask

  initial begin
    // simple op, 1-cycle completion
    rows[0]  = R(1, ADD(5), 0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[1]  = R(0, 0,      0, 0, E(1,1,5,  0,0,0, 0,0,0));
    rows[2]  = R(0, 0,      0, 0, E(1,0,0,  0,0,0, 0,0,0));
    // mul then add: ordered completion, then FIFO full back-pressure
    rows[3]  = R(1, MUL(7),  0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[4]  = R(1, ADD(3),  0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[5]  = R(1, ADD(10), 0, 0, E(0,1,7,  0,0,0, 0,0,0));
    rows[6]  = R(1, ADD(10), 0, 0, E(1,1,3,  0,0,0, 0,0,0));
    rows[7]  = R(0, 0,       0, 0, E(1,1,10, 0,0,0, 0,0,0));
    // float op is multicycle; reduction in OPMVV is not
    rows[8]  = R(1, FADD(12), 0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[9]  = R(0, 0,        0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[10] = R(0, 0,        0, 0, E(1,1,12, 0,0,0, 0,0,0));
    rows[11] = R(1, RED(13),  0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[12] = R(0, 0,        0, 0, E(1,1,13, 0,0,0, 0,0,0));
    // vset: accepted, dropped
    rows[13] = R(1, VSET(14), 0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[14] = R(0, 0,        0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[15] = R(0, 0,        0, 0, E(1,0,0,  0,0,0, 0,0,0));
    // load 9: request held 4 cycles, response 2 cycles after acceptance
    rows[16] = R(1, LD(9),  0, 0, E(1,0,0, 0,0,0, 0,0,0));
    rows[17] = R(0, 0,      0, 0, E(1,0,0, 1,0,9, 0,0,0));
    rows[18] = R(1, ST(20), 0, 0, E(0,0,0, 1,0,9, 0,0,0));
    rows[19] = R(0, 0,      0, 0, E(1,0,0, 1,0,9, 0,0,0));
    rows[20] = R(0, 0,      1, 0, E(1,0,0, 1,0,9, 0,0,0));
    rows[21] = R(1, ST(20), 0, 0, E(0,0,0, 0,0,0, 0,0,0));
    rows[22] = R(1, ST(20), 0, 1, E(0,0,0, 0,0,0, 0,0,0));
    rows[23] = R(0, 0,      0, 0, E(1,0,0, 0,0,0, 1,0,9));
    rows[24] = R(0, 0,      0, 0, E(1,0,0, 0,0,0, 0,0,0));
    // store 4 with same-cycle ready+response; load 6 taken in store_done cycle
    rows[25] = R(1, ST(4),   0, 0, E(1,0,0,  0,0,0, 0,0,0));
    rows[26] = R(1, LD(6),   1, 1, E(0,0,0,  1,1,4, 0,0,0));
    rows[27] = R(1, LD(6),   0, 0, E(1,0,0,  0,0,0, 0,1,4));
    rows[28] = R(0, 0,       1, 0, E(1,0,0,  1,0,6, 0,0,0));
    rows[29] = R(1, ADD(17), 0, 1, E(1,0,0,  0,0,0, 0,0,0));
    rows[30] = R(0, 0,       0, 0, E(1,1,17, 0,0,0, 1,0,6));
    rows[31] = R(0, 0,       0, 0, E(1,0,0,  0,0,0, 0,0,0));

    #3;
    cmp("reset_state", '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 32; i++) run_row($sformatf("row%0d", i), rows[i]);

    // Reset during WAIT with FIFO occupied
    run_row("rst_seq_ld",   R(1, LD(11),  0, 0, E(1,0,0,  0,0,0,  0,0,0)));
    run_row("rst_seq_mul",  R(1, MUL(21), 1, 0, E(1,0,0,  1,0,11, 0,0,0)));
    run_row("rst_seq_add",  R(1, ADD(22), 0, 0, E(1,0,0,  0,0,0,  0,0,0)));
    run_row("rst_seq_busy", R(0, 0,       0, 0, E(1,1,21, 0,0,0,  0,0,0)));
    #1;
    valid_vector = 1'b1;
    instruction  = ADD(23);
    rst          = 1'b0;
    #1;
    cmp("reset_async", '0);
    alu_q.delete();
    mem_q.delete();
    @(posedge clk);
    #1;
    cmp("reset_hold", '0);
    @(negedge clk);
    valid_vector = 1'b0;
    instruction  = '0;
    rst          = 1'b1;
    for (int i = 0; i < 4; i++)
      run_row($sformatf("post_rst_quiet%0d", i), R(0, 0, 1, 1, E(1,0,0, 0,0,0, 0,0,0)));
    run_row("post_rst_vset",  R(1, VSET(24), 0, 0, E(1,0,0,  0,0,0, 0,0,0)));
    run_row("post_rst_idle0", R(0, 0,        0, 0, E(1,0,0,  0,0,0, 0,0,0)));
    run_row("post_rst_idle1", R(0, 0,        0, 0, E(1,0,0,  0,0,0, 0,0,0)));
    run_row("post_rst_add",   R(1, ADD(25),  0, 0, E(1,0,0,  0,0,0, 0,0,0)));
    run_row("post_rst_done",  R(0, 0,        0, 0, E(1,1,25, 0,0,0, 0,0,0)));
    run_row("post_rst_idle2", R(0, 0,        0, 0, E(1,0,0,  0,0,0, 0,0,0)));

    checks++;
    if (alu_q.size() != 0 || mem_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d alu / %0d mem pending expected 0 / 0",
               alu_q.size(), mem_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_completion_unit.md
Name: vector_completion_unit

Overview:
Sits downstream of the vector dispatch scoreboard, on the receiving end of its issue handshake. It accepts issued vector instructions (valid_vector/ready_vector) and models the ALU and memory execution timing. It returns the completion events the scoreboard consumes: operation_done/alu_dest, read_done/store_done/mem_dest. It also drives a one-outstanding request/response interface toward the vector memory unit.

Parameters:
INSTRUCTION_BITS, 32, issued instruction width
REGISTER_NUMBERS, 32, vector register count; dest fields are $clog2(REGISTER_NUMBERS) bits
MULTICYCLE_OPERATION_CYCLES, 2, accept-to-result latency of mul/float ops (>=2)
ALU_QUEUE_DEPTH, 4, ALU completion FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
valid_vector  input  1  issue valid from scoreboard
instruction  input  INSTRUCTION_BITS  issued instruction
ready_vector  output  1  issue accept
mem_req_valid  output  1  memory request valid
mem_req_store  output  1  1=store, 0=load
mem_req_dest  output  $clog2(REGISTER_NUMBERS)  register of request
mem_req_ready  input  1  memory unit accepts request
mem_resp_valid  input  1  memory unit finished outstanding op
operation_done  output  1  ALU completion pulse
alu_dest  output  $clog2(REGISTER_NUMBERS)  register completed by ALU
read_done  output  1  load completion pulse
store_done  output  1  store completion pulse
mem_dest  output  $clog2(REGISTER_NUMBERS)  register completed by memory

Behaviour:
- Accept = valid_vector & ready_vector. dest = instruction[11:7].
- Decode:
  - alu_op: opcode[6:0]==1010111 and funct3!=111.
  - load: opcode==0000111. store: opcode==0100111.
  - multicycle: alu_op and (funct3 in {001,101}, or {funct3,funct6} in the scoreboard mul set: vmul/vmulh/vmulhu/vmulhsu, vmacc, vmadd; funct3 010 or 110).
  - Anything else, including vset, is accepted and dropped with no completion.
- ready_vector is combinational from the decode:
  - alu_op: 0 when FIFO count + in-flight multicycle >= ALU_QUEUE_DEPTH.
  - load/store: 0 when the memory FSM is not IDLE, unless a done pulse is asserted this cycle.
  - Otherwise 1.
- ALU path:
  - Simple op: dest is pushed to the completion FIFO at the end of the accept cycle.
  - Multicycle op: dest is loaded into a single countdown slot. It is pushed when the counter reaches MULTICYCLE_OPERATION_CYCLES-1, so the earliest operation_done comes MULTICYCLE_OPERATION_CYCLES cycles after accept.
  - The slot is single-entry (the scoreboard blocks a second multicycle issue). A multicycle accept while the slot is busy is an assertion error.
  - Simultaneous pushes: the slot entry (older) is written before the simple entry. The FIFO accepts 2 writes per cycle.
  - FIFO pops 1 per cycle: operation_done=1 and alu_dest=head, registered. A simple op alone with an empty FIFO gives operation_done 1 cycle after accept.
- Memory FSM: IDLE, REQ, WAIT, DONE.
  - IDLE: load/store accept -> REQ; latch dest and the store flag.
  - REQ: mem_req_valid=1, stable until mem_req_ready -> WAIT.
  - WAIT: mem_resp_valid -> DONE. A response arriving in the same cycle as mem_req_ready is legal: REQ -> DONE.
  - DONE: 1-cycle pulse of read_done (load) or store_done (store), with mem_dest. A new mem accept in this cycle goes straight to REQ; otherwise -> IDLE.
- Reset (rst=0, async): all outputs 0, FSM IDLE, FIFO empty, slot empty, counter 0. Reset mid-operation discards everything in flight with no completion pulses.
- operation_done and read_done/store_done may assert in the same cycle. They are independent.

Decomposition:
- Shared package vector_pkg: opcode constants (OP_V=1010111, OP_LOAD=0000111, OP_STORE=0100111), FUNCT3_VSET, the mul funct6/funct3 encodings, and mem_fsm_t {IDLE,REQ,WAIT,DONE}.
- The scoreboard decode should be migrated to these constants.
- Sub-module: alu_completion_fifo (2-write/1-read sync FIFO, depth ALU_QUEUE_DEPTH, count output).

Test Plan:
- Simple vadd.vv (funct3 000, dest=5) accepted at cycle 0 -> operation_done=1, alu_dest=5 at cycle 1 only.
- vmul (funct3 010, funct6 100101, dest=7), MULTICYCLE_OPERATION_CYCLES=2, then vadd dest=3 next cycle -> done dest=7 at cycle 2, dest=3 at cycle 3 (ordering under collision).
- 4 simple ops with FIFO back-pressure forced by a pending multicycle op -> ready_vector=0 at count 4; no entry lost; pulses in issue order.
- Load dest=9, mem_req_ready delayed 3 cycles, mem_resp 2 cycles later -> mem_req_valid held stable; read_done=1, mem_dest=9 for exactly 1 cycle; store offered during WAIT sees ready_vector=0.
- Store dest=4 finishing while a load dest=6 is valid -> load accepted in the store_done cycle; mem_req_valid next cycle with mem_req_dest=6, mem_req_store=0.
- rst asserted during WAIT with FIFO non-empty -> all outputs 0 immediately; no done pulses after release; vset instruction accepted with no completion.
